// File: rtl/mem_pkg.sv
// Shared definitions for the data-memory responder: FSM encoding, access sizes
// and the alignment rule.
package mem_pkg;

  localparam logic [1:0] IDLE  = 2'b00;
  localparam logic [1:0] ISSUE = 2'b01;
  localparam logic [1:0] DONE  = 2'b10;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  function automatic logic isAligned(input logic [1:0] off, input logic [1:0] size);
    case (size)
      SZ_B:    return 1'b1;
      SZ_H:    return ~off[0];
      SZ_W:    return (off == 2'b00);
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// RAM-side bus of the data-memory responder; master drives the access,
// slave is the backing RAM.
interface dmem_responder_if #(
  parameter int ADDR_W = 32
) ();

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [3:0]        mem_be;
  logic [31:0]       mem_wdata;
  logic              mem_ack;
  logic [31:0]       mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    output mem_ack, mem_rdata
  );

endinterface

// File: rtl/dmem_responder_load_align.sv
// Load data alignment: shift the read word down by the byte offset, truncate
// to the access size and sign- or zero-extend to 32 bits.
module load_align
  import mem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  offset,
  input  logic [1:0]  size,
  input  logic        isUnsigned,
  output logic [31:0] data
);

  logic [31:0] shifted;

  always_comb begin
    shifted = word >> {offset, 3'b000};
    case (size)
      SZ_B:    data = {{24{~isUnsigned & shifted[7]}},  shifted[7:0]};
      SZ_H:    data = {{16{~isUnsigned & shifted[15]}}, shifted[15:0]};
      default: data = shifted;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: holds the pipeline via ramReady while a load/store
// runs its request/ack handshake with the RAM, with misalign and timeout checks.
module dmem_responder
  import mem_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int ADDR_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [31:0]       req_wdata,
  output logic              ramReady,
  output logic [31:0]       rdata,
  output logic              misalign,
  output logic              bus_err,
  dmem_responder_if.master  mem
);

  localparam bit         TO_EN   = (TIMEOUT != 0);
  localparam logic [7:0] TO_SAT  = 8'(TIMEOUT);
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  logic [1:0]  state;
  logic [7:0]  cnt;
  logic [1:0]  offQ;
  logic [1:0]  sizeQ;
  logic        unsQ;
  logic        reqAligned;
  logic        timeoutHit;
  logic [3:0]  beNext;
  logic [31:0] loadData;

  load_align uAlign (
    .word       (mem.mem_rdata),
    .offset     (offQ),
    .size       (sizeQ),
    .isUnsigned (unsQ),
    .data       (loadData)
  );

  always_comb begin
    reqAligned = isAligned(req_addr[1:0], req_size);
    // The hold must rise in the very cycle a legal request shows up in IDLE.
    case (state)
      IDLE:    ramReady = ~(req_valid & reqAligned);
      ISSUE:   ramReady = 1'b0;
      default: ramReady = 1'b1;
    endcase
    case (req_size)
      SZ_B:    beNext = 4'b0001 << req_addr[1:0];
      SZ_H:    beNext = 4'b0011 << req_addr[1:0];
      default: beNext = 4'b1111;
    endcase
    // Leaving on the last counted cycle gives exactly TIMEOUT cycles of mem_req.
    timeoutHit = TO_EN && (cnt == TO_LAST);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      cnt           <= '0;
      offQ          <= '0;
      sizeQ         <= '0;
      unsQ          <= 1'b0;
      rdata         <= '0;
      misalign      <= 1'b0;
      bus_err       <= 1'b0;
      mem.mem_req   <= 1'b0;
      mem.mem_we    <= 1'b0;
      mem.mem_addr  <= '0;
      mem.mem_be    <= '0;
      mem.mem_wdata <= '0;
    end else begin
      misalign <= 1'b0;
      bus_err  <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            if (reqAligned) begin
              mem.mem_req   <= 1'b1;
              mem.mem_we    <= req_we;
              mem.mem_addr  <= {req_addr[ADDR_W-1:2], 2'b00};
              mem.mem_be    <= beNext;
              mem.mem_wdata <= req_wdata << {req_addr[1:0], 3'b000};
              offQ          <= req_addr[1:0];
              sizeQ         <= req_size;
              unsQ          <= req_unsigned;
              cnt           <= '0;
              state         <= ISSUE;
            end else begin
              misalign <= 1'b1;
            end
          end
        end
        ISSUE: begin
          // Ack has priority over a timeout landing in the same cycle.
          if (mem.mem_ack) begin
            rdata       <= loadData;
            mem.mem_req <= 1'b0;
            state       <= DONE;
          end else if (timeoutHit) begin
            rdata       <= '0;
            bus_err     <= 1'b1;
            mem.mem_req <= 1'b0;
            state       <= DONE;
          end else if (TO_EN && (cnt != TO_SAT)) begin
            cnt <= cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized scoreboard bench for dmem_responder against a behavioural model
// of the alignment, lane and timeout rules.
module tb_dmem_responder;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = '0;
  logic [1:0]  req_size = '0;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_wdata = '0;
  logic        ramReady;
  logic [31:0] rdata;
  logic        misalign;
  logic        bus_err;

  dmem_responder_if #(.ADDR_W(32)) bus ();

  dmem_responder #(.TIMEOUT(TO), .ADDR_W(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_we       (req_we),
    .req_addr     (req_addr),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_wdata    (req_wdata),
    .ramReady     (ramReady),
    .rdata        (rdata),
    .misalign     (misalign),
    .bus_err      (bus_err),
    .mem          (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          misal;
    bit          busErr;
    bit          isLoad;
    logic [31:0] rdata;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    int          reqCycles;
  } exp_t;

  exp_t        sbq[$];
  int          compared = 0;
  int          mismatched = 0;
  bit          monEn = 1'b0;
  int          ackDelay = 0;
  logic [31:0] ramWord = '0;
  int          ramCnt = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference: byte-lane arithmetic straight from the access rules.
  function automatic exp_t model(input logic we, input logic [31:0] addr, input logic [1:0] size,
                                 input logic uns, input logic [31:0] wd, input int delay,
                                 input logic [31:0] word);
    exp_t e;
    int nb, off;
    longint unsigned v, w, lim;
    nb  = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    off = int'(addr % 4);
    e.misal     = (size == 2'd3) || ((off % nb) != 0);
    e.isLoad    = !we;
    e.busErr    = (delay >= TO);
    e.reqCycles = e.busErr ? TO : delay + 1;
    e.we        = we;
    e.addr      = addr - 32'(off);
    for (int i = 0; i < 4; i++) e.be[i] = (i >= off) && (i < off + nb);
    w = longint'(wd);
    for (int i = 0; i < off; i++) w = w * 256;
    e.wdata = w[31:0];
    v = longint'(word);
    for (int i = 0; i < off; i++) v = v / 256;
    lim = 64'd1 << (8 * nb);
    v = v % lim;
    if (!uns && nb < 4 && v >= lim / 2) v = v + 64'h1_0000_0000 - lim;
    e.rdata = e.busErr ? 32'h0 : v[31:0];
    return e;
  endfunction

  // RAM: acks after the programmed number of mem_req cycles; random ack noise while idle.
  always @(negedge clk) begin
    if (bus.mem_req === 1'b1) begin
      bus.mem_ack   = (ramCnt == ackDelay);
      bus.mem_rdata = (ramCnt == ackDelay) ? ramWord : $urandom;
      ramCnt++;
    end else begin
      bus.mem_ack   = 1'($urandom_range(0, 1));
      bus.mem_rdata = $urandom;
      ramCnt        = 0;
    end
  end

  // Monitor: pops an expectation on each misalign pulse or each mem_req falling edge.
  bit prevReq = 1'b0;
  int reqCnt = 0;
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (!monEn || !rst_n) begin
      prevReq = 1'b0;
      reqCnt  = 0;
    end else begin
      if (bus.mem_req === 1'b1) begin
        reqCnt++;
        chk("ramReady_low_in_issue", 32'(ramReady), 32'd0);
      end
      if (misalign !== 1'b0) begin
        if (sbq.size() == 0) chk("misalign_unexpected", 32'(misalign), 32'd0);
        else begin
          e = sbq.pop_front();
          chk("misalign", 32'(misalign), 32'(e.misal));
          chk("misalign_no_mem_req", 32'(bus.mem_req), 32'd0);
        end
      end else if (prevReq && bus.mem_req !== 1'b1) begin
        if (sbq.size() == 0) chk("completion_unexpected", 32'(bus.mem_req), 32'd1);
        else begin
          e = sbq.pop_front();
          chk("misalign", 32'(misalign), 32'(e.misal));
          chk("ramReady_done", 32'(ramReady), 32'd1);
          chk("bus_err", 32'(bus_err), 32'(e.busErr));
          chk("mem_req_cycles", 32'(reqCnt), 32'(e.reqCycles));
          chk("mem_we", 32'(bus.mem_we), 32'(e.we));
          chk("mem_addr", bus.mem_addr, e.addr);
          chk("mem_be", 32'(bus.mem_be), 32'(e.be));
          if (e.we) chk("mem_wdata", bus.mem_wdata, e.wdata);
          if (e.isLoad || e.busErr) chk("rdata", rdata, e.rdata);
        end
        reqCnt = 0;
      end else if (bus_err !== 1'b0) begin
        chk("bus_err_stray", 32'(bus_err), 32'd0);
      end
      prevReq = (bus.mem_req === 1'b1);
    end
  end

  task automatic doReq(input logic we, input logic [31:0] addr, input logic [1:0] size,
                       input logic uns, input logic [31:0] wd, input int delay,
                       input logic [31:0] word);
    exp_t e;
    int n;
    e = model(we, addr, size, uns, wd, delay, word);
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_size = size;
    req_unsigned = uns; req_wdata = wd; ackDelay = delay; ramWord = word;
    sbq.push_back(e);
    #1;
    chk("ramReady_cycle0", 32'(ramReady), e.misal ? 32'd1 : 32'd0);
    n = 0;
    while (ramReady !== 1'b1 && n < 40) begin
      @(negedge clk); #1;
      n++;
    end
    if (n >= 40) chk("completion_within_bound", 32'(ramReady), 32'd1);
  endtask

  task automatic idle(input int k);
    repeat (k) begin
      @(negedge clk);
      req_valid = 1'b0;
      req_addr  = $urandom;
      req_size  = 2'($urandom_range(0, 3));
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mem_req", 32'(bus.mem_req), 32'd0);
    chk("rst_mem_we", 32'(bus.mem_we), 32'd0);
    chk("rst_mem_be", 32'(bus.mem_be), 32'd0);
    chk("rst_mem_addr", bus.mem_addr, 32'd0);
    chk("rst_mem_wdata", bus.mem_wdata, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_misalign", 32'(misalign), 32'd0);
    chk("rst_bus_err", 32'(bus_err), 32'd0);
    chk("rst_ramReady", 32'(ramReady), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    monEn = 1'b1;

    doReq(1'b0, 32'h100, 2'd2, 1'b0, 32'h0, 3, 32'hDEADBEEF);
    doReq(1'b0, 32'h103, 2'd0, 1'b0, 32'h0, 1, 32'h80123456);
    doReq(1'b0, 32'h103, 2'd0, 1'b1, 32'h0, 0, 32'h80123456);
    doReq(1'b1, 32'h102, 2'd1, 1'b0, 32'h1234, 2, 32'h0);
    doReq(1'b0, 32'h101, 2'd2, 1'b0, 32'h0, 0, 32'h0);
    doReq(1'b0, 32'h104, 2'd2, 1'b0, 32'h0, 50, 32'h11111111);
    doReq(1'b0, 32'h106, 2'd1, 1'b0, 32'h0, TO - 1, 32'h8001_7FFF);
    doReq(1'b1, 32'h108, 2'd3, 1'b0, 32'hFFFF, 0, 32'h0);
    idle(2);

    // Reset in the second ISSUE cycle, then a normal transaction.
    monEn = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h200; req_size = 2'd2; ackDelay = 100;
    @(negedge clk);
    @(negedge clk);
    chk("mid_issue_mem_req", 32'(bus.mem_req), 32'd1);
    rst_n = 1'b0; req_valid = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_mem_req", 32'(bus.mem_req), 32'd0);
    chk("post_rst_ramReady", 32'(ramReady), 32'd1);
    chk("post_rst_mem_be", 32'(bus.mem_be), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    monEn = 1'b1;
    doReq(1'b0, 32'h204, 2'd1, 1'b1, 32'h0, 1, 32'hCAFEF00D);

    for (int i = 0; i < 150; i++) begin
      logic [1:0] sz;
      sz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      doReq(1'($urandom_range(0, 1)), 32'h1000 + 32'($urandom_range(0, 255)), sz,
            1'($urandom_range(0, 1)), $urandom, int'($urandom_range(0, 6)), $urandom);
      if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 2)));
    end

    idle(5);
    chk("scoreboard_drained", 32'(sbq.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
